// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RV32I multi-cycle sequencer:
//   seq_state_t   sequencer FSM states
//   PC_SEL_*      decoder next-PC select encodings (2'b10 is reserved -> pc+4)
//   SRC_LOAD      decoder RF-source encoding that marks a load
//   OPC_SYSTEM    opcode of ECALL/EBREAK
//   OPC_FENCE     opcode of FENCE
//   NOP_INSTR     canonical NOP (addi x0,x0,0), IR contents after reset
// Optional feature macro used by the importing files: SEQ_TRAP_EN.
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXEC  = 3'd1,
      MEM   = 3'd2,
      WB    = 3'd3,
      HALT  = 3'd4
   } seq_state_t;

   localparam logic [1:0]  PC_SEL_PLUS4 = 2'b00;
   localparam logic [1:0]  PC_SEL_REL   = 2'b01;
   localparam logic [1:0]  PC_SEL_ABS   = 2'b11;

   localparam logic [1:0]  SRC_LOAD     = 2'b01;

   localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0]  OPC_FENCE    = 7'b0001111;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   // ECALL / EBREAK share the SYSTEM opcode; the funct fields are not needed
   // to decide whether the trap build halts.
   function automatic logic is_system(input logic [31:0] instr);
      return instr[6:0] == OPC_SYSTEM;
   endfunction

   // Instructions that the default build simply retires as pc+4 NOPs.
   function automatic logic retires_as_nop(input logic [31:0] instr);
      return (instr[6:0] == OPC_SYSTEM) || (instr[6:0] == OPC_FENCE);
   endfunction

endpackage

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-PC generator for the sequencer.
// Ports:
//   pc          in  32  current PC
//   sel         in   2  decoder next-PC select (00 +4, 01 relative, 11 absolute,
//                       10 reserved -> +4)
//   addr        in  32  decoder offset / absolute target
//   next_pc     out 32  next PC, wraps modulo 2^32
//   misaligned  out  1  next_pc[1:0] != 0
// ---------------------------------------------------------------------------
module pc_next
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  sel,
   input  logic [31:0] addr,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   always_comb begin
      next_pc = pc + 32'd4;
      case (sel)
         PC_SEL_PLUS4: next_pc = pc + 32'd4;
         PC_SEL_REL:   next_pc = pc + addr;
         PC_SEL_ABS:   next_pc = addr;
         default:      next_pc = pc + 32'd4;
      endcase
   end

   assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM of the RV32I core: fetches over a req/ack bus into
// the IR, drives the decoder, sequences data access and RF write-back, and
// owns the PC.  FETCH -> EXEC -> [MEM] -> WB -> FETCH.
// Optional feature: define SEQ_TRAP_EN to halt on ECALL/EBREAK and on
// misaligned next-PC targets (HALT state, left only through reset).
// Ports:
//   clk, reset_ni            clock / asynchronous active-low reset
//   i_req_o, i_addr_o        fetch request (held until ack) and address (=pc)
//   i_ack_i, i_data_i        fetch done, instruction word
//   d_req_o, d_ack_i         data access request (held until ack) / done
//   instr_o, dec_en_o        IR to decoder, decoder enable (EXEC..WB)
//   dec_next_pc_sel_i, dec_addr_i, dec_reg_in_src_i, dec_reg_in_en_i,
//   dec_d_we_i               decoder outputs steering the sequence
//   pc_o                     current PC
//   reg_we_o, retire_o       RF write strobe / retire pulse in WB
//   halt_o                   core halted (trap build only, else 0)
// ---------------------------------------------------------------------------
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset_ni,
   output logic        i_req_o,
   output logic [31:0] i_addr_o,
   input  logic        i_ack_i,
   input  logic [31:0] i_data_i,
   output logic        d_req_o,
   input  logic        d_ack_i,
   output logic [31:0] instr_o,
   output logic        dec_en_o,
   input  logic [1:0]  dec_next_pc_sel_i,
   input  logic [31:0] dec_addr_i,
   input  logic [1:0]  dec_reg_in_src_i,
   input  logic        dec_reg_in_en_i,
   input  logic        dec_d_we_i,
   output logic [31:0] pc_o,
   output logic        reg_we_o,
   output logic        retire_o,
   output logic        halt_o
);

   seq_state_t  state;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] next_pc;
   logic        misaligned;
   logic        mem_op;
   // Keeps i_req_o low through reset and until the first clock edge after
   // release, so the fetch request never rises while reset_ni is low.
   logic        started;

   pc_next u_pc_next (
      .pc         (pc),
      .sel        (dec_next_pc_sel_i),
      .addr       (dec_addr_i),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   assign mem_op = dec_d_we_i | (dec_reg_in_src_i == SRC_LOAD);

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         ir      <= NOP_INSTR;
         started <= 1'b0;
      end else begin
         started <= 1'b1;
         case (state)
            FETCH: begin
               if (started && i_ack_i) begin
                  ir    <= i_data_i;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (mem_op) state <= MEM;
               else        state <= WB;
`ifdef SEQ_TRAP_EN
               if (is_system(ir)) state <= HALT;
`endif
            end
            MEM: begin
               if (d_ack_i) state <= WB;
            end
            WB: begin
`ifdef SEQ_TRAP_EN
               // A misaligned target halts with the PC left at the
               // offending instruction.
               if (misaligned) begin
                  state <= HALT;
               end else begin
                  pc    <= next_pc;
                  state <= FETCH;
               end
`else
               pc    <= next_pc;
               state <= FETCH;
`endif
            end
`ifdef SEQ_TRAP_EN
            HALT:    state <= HALT;
`endif
            default: state <= FETCH;
         endcase
      end
   end

   // All strobes decode straight from state so an asynchronous reset clears
   // them immediately, abandoning any bus transaction in flight.
   assign i_req_o  = started && (state == FETCH);
   assign i_addr_o = pc;
   assign pc_o     = pc;
   assign instr_o  = ir;
   assign d_req_o  = (state == MEM);
   assign dec_en_o = (state == EXEC) || (state == MEM) || (state == WB);
   assign reg_we_o = (state == WB) && dec_reg_in_en_i;
   assign retire_o = (state == WB);

`ifdef SEQ_TRAP_EN
   assign halt_o = (state == HALT);
`else
   assign halt_o = 1'b0;
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed plus randomized bench for cpu_sequencer.  The bench plays the bus
// slaves and the decoder, and predicts every strobe and the PC from the
// instruction-level rules (phase lengths, next-PC arithmetic).
// Honours SEQ_TRAP_EN for the ECALL case.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        i_req, i_ack, d_req, d_ack, dec_en;
   logic [31:0] i_addr, i_data, instr, dec_addr, pc;
   logic [1:0]  dec_sel, dec_src;
   logic        dec_ren, dec_we;
   logic        reg_we, retire, halt;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc;
   logic        halted = 1'b0;

   always #5 clk = ~clk;

   cpu_sequencer #(.RESET_PC(32'h0000_0100)) dut (
      .clk               (clk),
      .reset_ni          (reset_ni),
      .i_req_o           (i_req),
      .i_addr_o          (i_addr),
      .i_ack_i           (i_ack),
      .i_data_i          (i_data),
      .d_req_o           (d_req),
      .d_ack_i           (d_ack),
      .instr_o           (instr),
      .dec_en_o          (dec_en),
      .dec_next_pc_sel_i (dec_sel),
      .dec_addr_i        (dec_addr),
      .dec_reg_in_src_i  (dec_src),
      .dec_reg_in_en_i   (dec_ren),
      .dec_d_we_i        (dec_we),
      .pc_o              (pc),
      .reg_we_o          (reg_we),
      .retire_o          (retire),
      .halt_o            (halt)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural next-PC rule.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] s,
                                              input logic [31:0] a);
      if (s == 2'b01)      return p + a;
      else if (s == 2'b11) return a;
      else                 return p + 32'd4;
   endfunction

   // One whole instruction from the FETCH cycle through WB.  fw = fetch wait
   // cycles, mw = data wait cycles.  Stray acks are thrown at the phases that
   // must ignore them.
   task automatic run_instr(input logic [31:0] ins, input logic st, input logic [1:0] src,
                            input logic ren, input logic [1:0] sel, input logic [31:0] addr,
                            input int fw, input int mw);
      logic [31:0] nxt;
      logic        mem;
      mem      = st | (src == 2'b01);
      dec_we   = st;
      dec_src  = src;
      dec_ren  = ren;
      dec_sel  = sel;
      dec_addr = addr;
      for (int w = 0; w <= fw; w++) begin
         chk1 ("fetch_req",   i_req,  1'b1);
         chk32("fetch_addr",  i_addr, m_pc);
         chk1 ("fetch_dreq",  d_req,  1'b0);
         chk1 ("fetch_ret",   retire, 1'b0);
         chk1 ("fetch_decen", dec_en, 1'b0);
         i_ack  = (w == fw);
         i_data = (w == fw) ? ins : $urandom;
         d_ack  = 1'($urandom_range(0, 1));
         tick();
      end
      chk1 ("exec_decen", dec_en, 1'b1);
      chk32("exec_ir",    instr,  ins);
      chk1 ("exec_ireq",  i_req,  1'b0);
      chk1 ("exec_dreq",  d_req,  1'b0);
      chk1 ("exec_ret",   retire, 1'b0);
      i_ack  = 1'($urandom_range(0, 1));
      i_data = $urandom;
      d_ack  = 1'b0;
      tick();
`ifdef SEQ_TRAP_EN
      if (ins[6:0] == 7'b1110011) begin
         for (int k = 0; k < 3; k++) begin
            chk1("halt_flag", halt,   1'b1);
            chk1("halt_ret",  retire, 1'b0);
            chk1("halt_ireq", i_req,  1'b0);
            chk1("halt_we",   reg_we, 1'b0);
            tick();
         end
         halted = 1'b1;
         return;
      end
`endif
      if (mem) begin
         for (int w = 0; w <= mw; w++) begin
            chk1("mem_dreq",  d_req,  1'b1);
            chk1("mem_decen", dec_en, 1'b1);
            chk1("mem_ret",   retire, 1'b0);
            chk1("mem_we",    reg_we, 1'b0);
            chk1("mem_ireq",  i_req,  1'b0);
            d_ack  = (w == mw);
            i_ack  = 1'($urandom_range(0, 1));
            i_data = $urandom;
            tick();
         end
         d_ack = 1'b0;
      end
      chk1 ("wb_we",    reg_we, ren);
      chk1 ("wb_ret",   retire, 1'b1);
      chk1 ("wb_decen", dec_en, 1'b1);
      chk1 ("wb_dreq",  d_req,  1'b0);
      chk1 ("wb_ireq",  i_req,  1'b0);
      chk32("wb_pc",    pc,     m_pc);
      chk32("wb_ir",    instr,  ins);
      nxt    = model_next(m_pc, sel, addr);
      i_ack  = 1'($urandom_range(0, 1));
      i_data = $urandom;
      tick();
      i_ack  = 1'b0;
      m_pc   = nxt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins, a;
      logic [1:0]  s;
      int          kind;

      reset_ni = 1'b1;
      i_ack = 1'b0; i_data = '0; d_ack = 1'b0;
      dec_sel = 2'b00; dec_addr = '0; dec_src = 2'b00; dec_ren = 1'b0; dec_we = 1'b0;
      #1 reset_ni = 1'b0;
      #1;
      // Reset: every strobe low, IR holds the NOP, PC at RESET_PC.
      chk1 ("rst_ireq",  i_req,  1'b0);
      chk1 ("rst_dreq",  d_req,  1'b0);
      chk1 ("rst_decen", dec_en, 1'b0);
      chk1 ("rst_we",    reg_we, 1'b0);
      chk1 ("rst_ret",   retire, 1'b0);
      chk1 ("rst_halt",  halt,   1'b0);
      chk32("rst_ir",    instr,  32'h0000_0013);
      chk32("rst_pc",    pc,     32'h0000_0100);
      i_ack = 1'b1;
      tick();
      chk1 ("rst_ireq_held", i_req, 1'b0);
      i_ack = 1'b0;
      @(negedge clk);
      reset_ni = 1'b1;
      tick();
      chk1 ("post_rst_ireq", i_req,  1'b1);
      chk32("post_rst_addr", i_addr, 32'h0000_0100);
      m_pc = 32'h0000_0100;

      // ADDI x1,x0,5 with a zero-wait fetch.
      run_instr(32'h0050_0093, 1'b0, 2'b00, 1'b1, 2'b00, 32'h0, 0, 0);
      chk32("addi_pc", pc, 32'h0000_0104);
      // LW with a five-cycle data wait, then a store.
      run_instr(32'h0000_2083, 1'b0, 2'b01, 1'b1, 2'b00, 32'h0, 0, 5);
      chk1 ("lw_no_second_dreq", d_req, 1'b0);
      run_instr(32'h0010_2023, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 1, 2);
      // JALR to 4, then JAL -8 wraps to 0xFFFF_FFFC, then JALR to 0x200.
      run_instr(32'h0000_00E7, 1'b0, 2'b10, 1'b1, 2'b11, 32'h0000_0004, 0, 0);
      chk32("jalr_to_4", i_addr, 32'h0000_0004);
      run_instr(32'hFF9F_F0EF, 1'b0, 2'b10, 1'b1, 2'b01, 32'hFFFF_FFF8, 0, 0);
      chk32("jal_wrap", i_addr, 32'hFFFF_FFFC);
      run_instr(32'h2000_0067, 1'b0, 2'b10, 1'b0, 2'b11, 32'h0000_0200, 2, 0);
      chk32("jalr_abs", i_addr, 32'h0000_0200);

      // Randomized instruction mix.
      for (int n = 0; n < 40; n++) begin
         ins = $urandom;
         if (ins[6:0] == 7'b1110011) ins[6:0] = 7'b0110011;
         a    = $urandom & 32'hFFFF_FFFC;
         kind = $urandom_range(0, 4);
         s    = 2'($urandom_range(0, 2));
         if (s == 2'b01) s = 2'b11;
         case (kind)
            0: run_instr(ins, 1'b0, s,     1'b1, 2'($urandom_range(0, 1)) << 1, a,
                         $urandom_range(0, 3), 0);
            1: run_instr(ins, 1'b0, 2'b01, 1'b1, 2'b00, a,
                         $urandom_range(0, 3), $urandom_range(0, 4));
            2: run_instr(ins, 1'b1, 2'b00, 1'b0, 2'b00, a,
                         $urandom_range(0, 3), $urandom_range(0, 4));
            3: run_instr(ins, 1'b0, s,     1'b0, 2'b01, a,
                         $urandom_range(0, 3), 0);
            default: run_instr(ins, 1'b0, 2'b10, 1'b1, 2'b11, a,
                               $urandom_range(0, 3), 0);
         endcase
      end

      // Reset pulled mid-MEM: d_req must drop at once, stray d_ack ignored.
      dec_we = 1'b0; dec_src = 2'b01; dec_ren = 1'b1; dec_sel = 2'b00;
      i_ack = 1'b1; i_data = 32'h0000_2083;
      tick();
      i_ack = 1'b0;
      tick();
      chk1("mid_mem_dreq", d_req, 1'b1);
      tick();
      chk1("mid_mem_dreq2", d_req, 1'b1);
      #2 reset_ni = 1'b0;
      #1;
      chk1("async_dreq",  d_req,  1'b0);
      chk1("async_decen", dec_en, 1'b0);
      chk1("async_ireq",  i_req,  1'b0);
      d_ack = 1'b1;
      tick();
      chk1("rst_stray_dreq", d_req, 1'b0);
      @(negedge clk);
      reset_ni = 1'b1;
      tick();
      chk1 ("rerun_ireq", i_req,  1'b1);
      chk32("rerun_addr", i_addr, 32'h0000_0100);
      chk1 ("rerun_dreq", d_req,  1'b0);
      d_ack = 1'b0;
      m_pc  = 32'h0000_0100;
      run_instr(32'h0050_0093, 1'b0, 2'b00, 1'b1, 2'b00, 32'h0, 1, 0);

      // ECALL: retires as a NOP by default, halts in the trap build.
      run_instr(32'h0000_0073, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 0, 0);
      if (halted) begin
         chk1("ecall_halt_stays", halt, 1'b1);
      end else begin
         chk32("ecall_pc4", i_addr, 32'h0000_0108);
         chk1 ("ecall_next_req", i_req, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
